// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - coin change dispenser with per-denomination inventory
//
// Purpose: pays a change request given in nickel units. It ejects one coin at a
// time, choosing greedily in the order quarter, dime, nickel, and never goes back
// to reconsider a choice. Each denomination has an inventory counter. A rising
// edge on a coin input adds one to it, and every dispense takes one away.
//
// Optional build macro: CHANGE_INV_OUT_EN exposes the live inventory counts and a
// low_stock flag as extra outputs.
//
// Ports:
//   CLK                 clock, rising edge
//   RESET               synchronous active-low reset
//   start, amount       request strobe and change due (nickel units), taken in IDLE
//   inquarter/indime/innickle   deposit levels, one rising edge per coin
//   busy                high in every state except IDLE
//   done, short         one-cycle completion pulse; short = amount left unpaid
//   remaining           amount not yet paid, holds after done
//   outquarter/outdime/outnickle coin eject pulses, at most one high at a time
//   inv_quarter/inv_dime/inv_nickle, low_stock (CHANGE_INV_OUT_EN only)
module change_dispenser #(
  parameter int AMT_W        = 6,
  parameter int INV_W        = 8,
  parameter int Q_INIT       = 20,
  parameter int D_INIT       = 20,
  parameter int N_INIT       = 20,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             inquarter,
  input  logic             indime,
  input  logic             innickle,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
`ifdef CHANGE_INV_OUT_EN
  output logic [INV_W-1:0] inv_quarter,
  output logic [INV_W-1:0] inv_dime,
  output logic [INV_W-1:0] inv_nickle,
  output logic             low_stock,
`endif
  output logic             outquarter,
  output logic             outdime,
  output logic             outnickle
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_FINISH} state_t;
  typedef enum logic [1:0] {C_NONE, C_QUARTER, C_DIME, C_NICKLE} coin_t;

  localparam logic [INV_W-1:0] INV_MAX    = '1;
  localparam logic [15:0]      PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0]      GAP_LAST   = 16'(GAP_CYCLES - 1);

  state_t           state, state_nxt;
  coin_t            coin, coin_pick;
  logic [AMT_W-1:0] rem, coin_val;
  logic [INV_W-1:0] q_cnt, d_cnt, n_cnt;
  logic [2:0]       in_prev, dep;
  logic [15:0]      cnt;

  // Each deposit input is a level that rises once per coin, so a coin is
  // counted on the rising edge of its input.
  assign dep = {inquarter, indime, innickle} & ~in_prev;

  // A deposit and a dispense in the same cycle cancel each other. A full
  // counter ignores further deposits. SELECT only dispenses a coin whose
  // count is nonzero, so the decrement can never wrap.
  function automatic logic [INV_W-1:0] inv_next(input logic [INV_W-1:0] cur,
                                                input logic deposit,
                                                input logic dispense);
    if (deposit && !dispense)
      return (cur == INV_MAX) ? cur : cur + 1'b1;
    else if (dispense && !deposit)
      return cur - 1'b1;
    else
      return cur;
  endfunction

  always_comb begin
    state_nxt  = state;
    coin_pick  = C_NONE;
    coin_val   = '0;
    done       = 1'b0;
    short      = 1'b0;
    outquarter = 1'b0;
    outdime    = 1'b0;
    outnickle  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_SELECT;
      S_SELECT: begin
        // The thresholds guarantee that remaining never underflows.
        if (rem >= AMT_W'(5) && q_cnt != '0) begin
          coin_pick = C_QUARTER;
          coin_val  = AMT_W'(5);
        end else if (rem >= AMT_W'(2) && d_cnt != '0) begin
          coin_pick = C_DIME;
          coin_val  = AMT_W'(2);
        end else if (rem != '0 && n_cnt != '0) begin
          coin_pick = C_NICKLE;
          coin_val  = AMT_W'(1);
        end
        state_nxt = (coin_pick == C_NONE) ? S_FINISH : S_PULSE;
      end
      S_PULSE: begin
        outquarter = (coin == C_QUARTER);
        outdime    = (coin == C_DIME);
        outnickle  = (coin == C_NICKLE);
        if (cnt == PULSE_LAST) state_nxt = S_GAP;
      end
      S_GAP: if (cnt == GAP_LAST) state_nxt = S_SELECT;
      S_FINISH: begin
        done      = 1'b1;
        short     = (rem != '0);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    busy = (state != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= S_IDLE;
      coin    <= C_NONE;
      rem     <= '0;
      cnt     <= '0;
      in_prev <= '0;
      q_cnt   <= INV_W'(Q_INIT);
      d_cnt   <= INV_W'(D_INIT);
      n_cnt   <= INV_W'(N_INIT);
    end else begin
      state   <= state_nxt;
      in_prev <= {inquarter, indime, innickle};
      q_cnt   <= inv_next(q_cnt, dep[2], coin_pick == C_QUARTER);
      d_cnt   <= inv_next(d_cnt, dep[1], coin_pick == C_DIME);
      n_cnt   <= inv_next(n_cnt, dep[0], coin_pick == C_NICKLE);
      // The pulse and gap timer restarts on every state change.
      cnt     <= (state_nxt != state) ? '0 : cnt + 16'd1;
      if (state == S_IDLE && start) rem <= amount;
      if (coin_pick != C_NONE) begin
        rem  <= rem - coin_val;
        coin <= coin_pick;
      end
    end
  end

  assign remaining = rem;

`ifdef CHANGE_INV_OUT_EN
  assign inv_quarter = q_cnt;
  assign inv_dime    = d_cnt;
  assign inv_nickle  = n_cnt;
  assign low_stock   = (q_cnt < INV_W'(2)) || (d_cnt < INV_W'(2)) || (n_cnt < INV_W'(2));
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized self-checking bench for change_dispenser
module tb_change_dispenser;
  localparam int AMT_W = 6;
  localparam int INV_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             start = 1'b0, inquarter = 1'b0, indime = 1'b0, innickle = 1'b0;
  logic [AMT_W-1:0] amount = '0;
  logic             busy, done, short, outquarter, outdime, outnickle;
  logic [AMT_W-1:0] remaining;

  logic             start_b = 1'b0;
  logic [AMT_W-1:0] amount_b = '0;
  logic             busy_b, done_b, short_b, outquarter_b, outdime_b, outnickle_b;
  logic [AMT_W-1:0] remaining_b;

`ifdef CHANGE_INV_OUT_EN
  logic [INV_W-1:0] inv_q, inv_d, inv_n, inv_q_b, inv_d_b, inv_n_b;
  logic             low_stock, low_stock_b;
`endif

  change_dispenser dut (
    .CLK(clk), .RESET(rst_n), .start(start), .amount(amount),
    .inquarter(inquarter), .indime(indime), .innickle(innickle),
    .busy(busy), .done(done), .short(short), .remaining(remaining),
`ifdef CHANGE_INV_OUT_EN
    .inv_quarter(inv_q), .inv_dime(inv_d), .inv_nickle(inv_n), .low_stock(low_stock),
`endif
    .outquarter(outquarter), .outdime(outdime), .outnickle(outnickle)
  );

  // Scarce-inventory instance: one quarter, no nickels.
  change_dispenser #(.Q_INIT(1), .D_INIT(20), .N_INIT(0)) dut_b (
    .CLK(clk), .RESET(rst_n), .start(start_b), .amount(amount_b),
    .inquarter(1'b0), .indime(1'b0), .innickle(1'b0),
    .busy(busy_b), .done(done_b), .short(short_b), .remaining(remaining_b),
`ifdef CHANGE_INV_OUT_EN
    .inv_quarter(inv_q_b), .inv_dime(inv_d_b), .inv_nickle(inv_n_b), .low_stock(low_stock_b),
`endif
    .outquarter(outquarter_b), .outdime(outdime_b), .outnickle(outnickle_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Coin pulses seen on the main instance, as nickel-unit values.
  int       obs_q[$];
  int       multi_hot = 0;
  logic [2:0] prev_out = '0;
  always @(negedge clk) begin
    if ($countones({outquarter, outdime, outnickle}) > 1) multi_hot++;
    if (outquarter && !prev_out[2]) obs_q.push_back(5);
    if (outdime    && !prev_out[1]) obs_q.push_back(2);
    if (outnickle  && !prev_out[0]) obs_q.push_back(1);
    prev_out = {outquarter, outdime, outnickle};
  end

  // Reference inventory of the main instance.
  int mq = 20, md = 20, mn = 20;

  task automatic model_reset();
    mq = 20; md = 20; mn = 20;
  endtask

  task automatic check_inv(input string tag);
`ifdef CHANGE_INV_OUT_EN
    check({tag, "_invq"}, inv_q, mq);
    check({tag, "_invd"}, inv_d, md);
    check({tag, "_invn"}, inv_n, mn);
    check({tag, "_low"}, low_stock, (mq < 2 || md < 2 || mn < 2));
`else
    checks += 0;
`endif
  endtask

  task automatic deposit(input int which);
    @(negedge clk);
    case (which)
      0: inquarter = 1'b1;
      1: indime = 1'b1;
      default: innickle = 1'b1;
    endcase
    @(negedge clk);
    inquarter = 1'b0; indime = 1'b0; innickle = 1'b0;
    case (which)
      0: mq = (mq < 255) ? mq + 1 : mq;
      1: md = (md < 255) ? md + 1 : md;
      default: mn = (mn < 255) ? mn + 1 : mn;
    endcase
  endtask

  // One full transaction on the main instance against the greedy reference.
  task automatic run_txn(input int amt, input string tag);
    int exp_coins[$];
    int r = amt;
    int n_done = -1;
    while (1) begin
      if (r >= 5 && mq > 0) begin exp_coins.push_back(5); r -= 5; mq--; end
      else if (r >= 2 && md > 0) begin exp_coins.push_back(2); r -= 2; md--; end
      else if (r >= 1 && mn > 0) begin exp_coins.push_back(1); r -= 1; mn--; end
      else break;
    end
    @(negedge clk);
    obs_q.delete();
    start = 1'b1;
    amount = AMT_W'(amt);
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 400 && n_done < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check({tag, "_busy1"}, busy, 1);
      if (done) begin
        n_done = cyc;
        check({tag, "_short"}, short, (r != 0));
        check({tag, "_remaining"}, remaining, r);
      end
    end
    check({tag, "_done_cycle"}, n_done, 3 * exp_coins.size() + 2);
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_ncoins"}, obs_q.size(), exp_coins.size());
    for (int i = 0; i < exp_coins.size() && i < obs_q.size(); i++)
      check($sformatf("%s_coin%0d", tag, i), obs_q[i], exp_coins[i]);
    check_inv(tag);
  endtask

  initial begin
    // Reset held for two edges.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_short", short, 0);
    check("rst_remaining", remaining, 0);
    check("rst_outs", {outquarter, outdime, outnickle}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check_inv("post_rst");

    run_txn(8, "amt8");
    run_txn(0, "amt0");

    // Scarce instance: 6 units with one quarter and no nickels ends short by 1.
    begin
      int n_done = -1, nq = 0, nn = 0;
      @(negedge clk);
      start_b = 1'b1; amount_b = AMT_W'(6);
      @(posedge clk);
      #1 start_b = 1'b0;
      for (int cyc = 1; cyc <= 50 && n_done < 0; cyc++) begin
        @(negedge clk);
        if (outquarter_b) nq++;
        if (outnickle_b) nn++;
        if (done_b) begin
          n_done = cyc;
          check("scarce_short", short_b, 1);
          check("scarce_remaining", remaining_b, 1);
        end
      end
      check("scarce_done_cycle", n_done, 5);
      check("scarce_quarters", nq, 1);
      check("scarce_nickels", nn, 0);
    end

    // Ten-quarter payout with an ignored second start and three deposits.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    fork
      run_txn(50, "q10");
      begin
        repeat (6) @(negedge clk);
        start = 1'b1; amount = AMT_W'(3);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
          inquarter = 1'b1;
          @(negedge clk);
          inquarter = 1'b0;
          @(negedge clk);
        end
      end
    join
    mq += 3;
    check("q10_model_quarters", mq, 13);
    check_inv("q10_final");
    // 12 quarters leave exactly one, so 5 units must come back as a quarter.
    run_txn(63, "drain63");
    run_txn(5, "last_quarter");

    // Reset while a dime is being ejected.
    begin
      int seen = 0, n_done = 0;
      @(negedge clk);
      start = 1'b1; amount = AMT_W'(2);
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 0; cyc < 10 && seen == 0; cyc++) begin
        @(negedge clk);
        if (outdime) seen = 1;
      end
      check("abort_dime_seen", seen, 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("abort_outdime", outdime, 0);
      check("abort_busy", busy, 0);
      repeat (5) begin
        @(negedge clk);
        if (done) n_done++;
      end
      check("abort_no_done", n_done, 0);
      model_reset();
      run_txn(1, "after_abort");
    end

    // Random amounts and deposits between requests; inventories drain over time.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1) deposit(int'($urandom_range(0, 2)));
      run_txn(int'($urandom_range(0, 63)), $sformatf("rnd%0d", t));
    end

    check("one_hot_violations", multi_hot, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sequences coin ejection for the vending controller's change and coin-return path.
- Accepts a change request in nickel units and drives one coin-out pulse at a time: quarter, then dime, then nickel.
- Keeps a per-denomination coin inventory, credited by coin-input pulses and debited by each dispense.
- Reports completion, and a shortfall when exact change cannot be paid.

Parameters:
- AMT_W, 6, width of the amount in nickel units (max 63 = $3.15).
- INV_W, 8, width of each inventory counter.
- Q_INIT, 20, quarter inventory after reset.
- D_INIT, 20, dime inventory after reset.
- N_INIT, 20, nickel inventory after reset.
- PULSE_CYCLES, 1, coin-out high time in cycles (>=1).
- GAP_CYCLES, 1, low time between coin pulses in cycles (>=1).

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- amount  in  AMT_W  change due, in nickel units; latched with start.
- inquarter  in  1  quarter deposited; level, one rising edge per coin.
- indime  in  1  dime deposited; same convention.
- innickle  in  1  nickel deposited; same convention.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- short  out  1  valid when done=1; high if the remaining amount is nonzero.
- remaining  out  AMT_W  amount not yet paid; holds its final value after done.
- outquarter  out  1  quarter eject pulse.
- outdime  out  1  dime eject pulse.
- outnickle  out  1  nickel eject pulse.

Behaviour:
- Reset (RESET=0 at an edge):
  - state=IDLE; all outputs 0; remaining=0.
  - Inventories load Q_INIT/D_INIT/N_INIT; deposit edge detectors clear.
  - Reset mid-dispense aborts immediately: no done, and any coin pulse drops on the next cycle.
- States: IDLE, SELECT, PULSE, GAP, FINISH.
- IDLE:
  - start=1 latches amount into remaining and moves to SELECT.
  - start in any other state is ignored.
- SELECT (1 cycle), greedy choice in priority order:
  - remaining>=5 and quarter inventory>0: quarter.
  - else remaining>=2 and dime inventory>0: dime.
  - else remaining>=1 and nickel inventory>0: nickel.
  - else go to FINISH.
  - On a choice: move to PULSE; remaining decrements by 5/2/1 and the chosen inventory by 1 at that same edge.
- PULSE:
  - The chosen coin output is high for exactly PULSE_CYCLES cycles; only one coin output is ever high at a time.
  - Then GAP.
- GAP: all coin outputs low for GAP_CYCLES cycles, then SELECT.
- FINISH (1 cycle): done=1, short=(remaining!=0), busy=1; next state IDLE.
- busy is low only in IDLE. done and short are 0 outside FINISH.
- Latency, PULSE=GAP=1, one quarter:
  - start sampled at edge 0.
  - SELECT in cycle 1, outquarter in cycle 2, GAP in cycle 3, SELECT in cycle 4, done in cycle 5.
  - IDLE and busy=0 in cycle 6.
- amount=0: SELECT then FINISH; done in cycle 2, short=0, no coin pulses.
- Greedy is final, with no backtracking. Example: 6 units with 1 quarter and 0 nickels pays the quarter, then ends short with remaining=1.
- Deposits:
  - A rising edge on inquarter/indime/innickle increments that inventory, in any state including during dispense.
  - Inventory saturates at 2^INV_W-1.
  - Deposit and dispense of the same denomination in the same cycle leave the count unchanged.
  - A deposit during reset is not counted.
- Arithmetic: remaining never underflows, because the SELECT thresholds guarantee it. Inventory never goes below 0.

Optional Feature:
- Macro CHANGE_INV_OUT_EN.
- When defined: adds output ports inv_quarter, inv_dime, inv_nickle (each INV_W) carrying the live inventory counts, plus low_stock (1), high when any count is below 2.
- When undefined: those ports and low_stock do not exist; the internal behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0, busy=0. With the macro: inventories 20/20/20, low_stock=0.
- start with amount=8 (40c), full inventory -> exactly one outquarter, one dime, one nickel pulse, in that order with gaps. done in cycle 11, short=0, remaining=0; counts 19/19/19.
- amount=0 -> done in cycle 2, short=0, no coin pulse, busy high for cycles 1-2 only.
- Reset to Q_INIT=1, N_INIT=0; amount=6 -> one quarter then FINISH; short=1, remaining=1, no nickel pulse.
- During a 10-quarter payout, pulse start again and toggle inquarter 3 times -> second start ignored. 10 quarter pulses occur and the final quarter count is 20-10+3=13.
- Deassert RESET for one edge while outdime is high -> outdime low next cycle, no done pulse; the next start with amount=1 dispenses one nickel normally.
